// File: rtl/tpu_pkg.sv
// Shared TPU constants: memory-map bases and the host sequencer state encoding.
package tpu_pkg;

  localparam logic [15:0] A_BASE      = 16'h0100;
  localparam logic [15:0] B_BASE      = 16'h0200;
  localparam logic [15:0] C_BASE      = 16'h0300;
  localparam logic [15:0] CMD_RUN     = 16'h0400;
  localparam int          ADDR_STRIDE = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LD_A = 3'd1,
    S_LD_B = 3'd2,
    S_LD_C = 3'd3,
    S_KICK = 3'd4,
    S_WAIT = 3'd5,
    S_RD_C = 3'd6
  } seq_state_t;

endpackage

// File: rtl/tpu_out_reg.sv
// One-entry valid/ready output register. Accepts a capture when empty or when
// the held word is leaving in the same cycle, so full throughput is one word/cycle.
module tpu_out_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cap,
  input  logic [W-1:0] cap_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Next state: a capture always wins; otherwise a drain empties the slot.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (cap) begin
      valid_d = 1'b1;
      data_d  = cap_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/tpu_seq.sv
// Host-side command sequencer for the TPU memory-mapped core: streams A, B and C
// into the core, fires the run command, waits out the compute window and then
// streams the C half-rows back out.
module tpu_seq
  import tpu_pkg::*;
#(
  parameter int DIM         = 8,
  parameter int BITS_AB     = 8,
  parameter int BITS_C      = 16,
  parameter int ADDRW       = 16,
  parameter int DATAW       = 64,
  parameter int COMPUTE_CYC = 2*DIM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_dataIn,
  input  logic [DATAW-1:0] tpu_dataOut
);

  // Words per matrix: one bus word per A/B row, two half-words per C row at defaults.
  localparam int AB_WORDS = DIM * ((DIM*BITS_AB + DATAW - 1) / DATAW);
  localparam int C_WORDS  = DIM * ((DIM*BITS_C  + DATAW - 1) / DATAW);
  localparam int CNT_MAX  = (C_WORDS > COMPUTE_CYC) ? C_WORDS : COMPUTE_CYC;
  localparam int CNTW     = $clog2(CNT_MAX) + 1;

  seq_state_t      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            load, hs, cap, drain;
  logic [ADDRW-1:0] off;

  assign load  = (state_q == S_LD_A) || (state_q == S_LD_B) || (state_q == S_LD_C);
  assign hs    = load && in_valid;
  assign drain = out_valid && out_ready;
  // Only 2*DIM reads are issued; once cnt reaches the end we just wait for the drain.
  assign cap   = (state_q == S_RD_C) && (cnt_q < CNTW'(C_WORDS)) && (!out_valid || out_ready);

  assign busy       = (state_q != S_IDLE);
  assign in_ready   = load;
  assign tpu_r_w    = hs;
  assign tpu_dataIn = load ? in_data : '0;
  assign done       = (state_q == S_RD_C) && (cnt_q == CNTW'(C_WORDS)) && drain;

  // Next state and word counter; the counter clears on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LD_A;
      S_LD_A: if (hs) begin
        if (cnt_q == CNTW'(AB_WORDS-1)) begin state_d = S_LD_B; cnt_d = '0; end
        else cnt_d = cnt_q + 1'b1;
      end
      S_LD_B: if (hs) begin
        if (cnt_q == CNTW'(AB_WORDS-1)) begin state_d = S_LD_C; cnt_d = '0; end
        else cnt_d = cnt_q + 1'b1;
      end
      S_LD_C: if (hs) begin
        if (cnt_q == CNTW'(C_WORDS-1)) begin state_d = S_KICK; cnt_d = '0; end
        else cnt_d = cnt_q + 1'b1;
      end
      S_KICK: state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_q == CNTW'(COMPUTE_CYC-1)) begin state_d = S_RD_C; cnt_d = '0; end
        else cnt_d = cnt_q + 1'b1;
      end
      S_RD_C: begin
        if (cap) cnt_d = cnt_q + 1'b1;
        if (done) begin state_d = S_IDLE; cnt_d = '0; end
      end
      default: begin state_d = S_IDLE; cnt_d = '0; end
    endcase
  end

  // Address mux: parked at 0x0000 outside the active windows so the run command
  // is seen for exactly one cycle and no stray access hits the core.
  always_comb begin
    off      = ADDRW'(cnt_q) * ADDRW'(ADDR_STRIDE);
    tpu_addr = '0;
    unique case (state_q)
      S_LD_A:         tpu_addr = ADDRW'(A_BASE) + off;
      S_LD_B:         tpu_addr = ADDRW'(B_BASE) + off;
      S_LD_C, S_RD_C: tpu_addr = ADDRW'(C_BASE) + off;
      S_KICK:         tpu_addr = ADDRW'(CMD_RUN);
      default:        tpu_addr = '0;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  tpu_out_reg #(.W(DATAW)) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap       (cap),
    .cap_data  (tpu_dataOut),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_tpu_seq.sv
// Directed bench for tpu_seq with a small TPU memory model that computes C = A*B
// when the run command is seen.
module tb_tpu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, busy, done;
  logic        in_valid, in_ready;
  logic [63:0] in_data;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic        tpu_r_w;
  logic [15:0] tpu_addr;
  logic [63:0] tpu_dataIn, tpu_dataOut;

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] words [32];
  logic [63:0] exp_out [16];
  logic [63:0] amem [8];
  logic [63:0] bmem [8];
  logic [63:0] cmem [16];

  always #5 clk = ~clk;

  tpu_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .tpu_r_w     (tpu_r_w),
    .tpu_addr    (tpu_addr),
    .tpu_dataIn  (tpu_dataIn),
    .tpu_dataOut (tpu_dataOut)
  );

  // C half-row q: row q/2, elements 4*(q%2)..+3 as 16-bit lanes.
  function automatic logic [63:0] mac_half(input int q);
    logic [63:0] r;
    int          s;
    r = '0;
    for (int e = 0; e < 4; e++) begin
      s = 0;
      for (int k = 0; k < 8; k++)
        s += int'(amem[q/2][8*k +: 8]) * int'(bmem[k][8*(4*(q%2)+e) +: 8]);
      r[16*e +: 16] = s[15:0];
    end
    return r;
  endfunction

  // TPU model: writes land in A/B/C, run command computes C, reads are combinational.
  always @(posedge clk) begin
    if (tpu_r_w) begin
      case (tpu_addr[15:8])
        8'h01:   amem[tpu_addr[5:3]] <= tpu_dataIn;
        8'h02:   bmem[tpu_addr[5:3]] <= tpu_dataIn;
        8'h03:   cmem[tpu_addr[6:3]] <= tpu_dataIn;
        default: ;
      endcase
    end else if (tpu_addr == 16'h0400) begin
      for (int q = 0; q < 16; q++) cmem[q] <= mac_half(q);
    end
  end

  assign tpu_dataOut = (tpu_addr[15:8] == 8'h03) ? cmem[tpu_addr[6:3]] : 64'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_addr(input int i);
    if (i < 8)       return 16'h0100 + 16'(8*i);
    else if (i < 16) return 16'h0200 + 16'(8*(i-8));
    else             return 16'h0300 + 16'(8*(i-16));
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".busy"},      busy,       0);
    check({tag, ".done"},      done,       0);
    check({tag, ".in_ready"},  in_ready,   0);
    check({tag, ".out_valid"}, out_valid,  0);
    check({tag, ".out_data"},  out_data,   0);
    check({tag, ".r_w"},       tpu_r_w,    0);
    check({tag, ".addr"},      tpu_addr,   0);
    check({tag, ".dataIn"},    tpu_dataIn, 0);
  endtask

  // One job. bubble: in_valid toggles; stall: out_ready low 5 cycles at addr 0x320;
  // poke: start pulsed during WAIT; abort_idx>=0: async reset once that many words went in.
  task automatic run_job(input bit bubble, input bit stall, input bit poke, input int abort_idx);
    int cyc = 0, idx = 0, oidx = 0, kick_n = 0, zero_run = 0, done_n = 0, done_cyc = -1;
    int stall_left = 0, post = 0;
    bit after_kick = 0, in_rd = 0, stalled = 0, poked = 0, abort_now = 0;
    logic [63:0] hold = '0;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    while (cyc < 400 && post < 20) begin
      if (abort_now) begin
        check("abort.pre_addr", tpu_addr, 16'h0218);
        in_valid = 1'b0; start = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_idle("abort.async");
        @(posedge clk); #1;
        check_idle("abort.next");
        rst_n = 1'b1;
        return;
      end
      in_valid = (idx < 32) && (!bubble || (cyc % 2 == 1));
      in_data  = (idx < 32) ? words[idx] : 64'h0;
      if (stall && !stalled && out_valid && tpu_addr == 16'h0320) begin
        stall_left = 5; stalled = 1; hold = out_data;
      end
      out_ready = (stall_left == 0);
      start = (poke && !poked && zero_run == 5);
      if (start) poked = 1;
      #1;
      if (in_ready) check("r_w_mirror", tpu_r_w, in_valid);
      if (in_ready && in_valid) begin
        check($sformatf("wr_addr[%0d]", idx), tpu_addr, exp_addr(idx));
        check($sformatf("wr_data[%0d]", idx), tpu_dataIn, words[idx]);
        idx++;
        if (idx == abort_idx) abort_now = 1;
      end
      if (tpu_addr == 16'h0400) begin kick_n++; after_kick = 1; end
      else if (after_kick && !in_rd) begin
        if (tpu_addr == 16'h0000) zero_run++; else in_rd = 1;
      end
      if (stall_left > 0) begin
        check("stall.addr", tpu_addr, 16'h0320);
        check("stall.data", out_data, hold);
        stall_left--;
      end
      if (out_valid && out_ready) begin
        if (oidx < 16) check($sformatf("out[%0d]", oidx), out_data, exp_out[oidx]);
        oidx++;
      end
      if (done) begin done_n++; if (done_cyc < 0) done_cyc = cyc; end
      if (done_n > 0) post++;
      @(posedge clk); #1;
      cyc++;
    end
    check("job.words_in",  idx,      32);
    check("job.words_out", oidx,     16);
    check("job.kick_cyc",  kick_n,   1);
    check("job.wait_zero", zero_run, 16);
    check("job.done_n",    done_n,   1);
    check("job.idle_end",  busy,     0);
    if (!bubble && !stall) check("job.done_cyc", done_cyc, 66);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      words[i]   = 64'h1 << (8*i);          // identity A
      words[8+i] = 64'h0807_0605_0403_0201; // every B row = 1..8
    end
    for (int i = 16; i < 32; i++) words[i] = 64'h0;
    for (int q = 0; q < 16; q++)
      exp_out[q] = (q % 2 == 0) ? 64'h0004_0003_0002_0001 : 64'h0008_0007_0006_0005;
    for (int q = 0; q < 16; q++) cmem[q] = 64'h0;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 64'h0; out_ready = 1'b1;
    #12 check_idle("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(0, 0, 0, -1);  // plain run, exact latency
    run_job(1, 0, 0, -1);  // input bubbles
    run_job(0, 1, 0, -1);  // output back-pressure
    run_job(0, 0, 1, -1);  // stray start during WAIT
    run_job(0, 0, 0, 11);  // async reset in LD_B with cnt=3
    run_job(0, 0, 0, -1);  // fresh job after reset restarts at A_BASE

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
